// File: rtl/uart_result_sequencer.sv
// rtl/uart_result_sequencer.sv - command-triggered result framer for a byte UART
// Frame: HEADER, result bytes MSB first, modulo-256 sum of the result bytes.
module uart_result_sequencer #(
   parameter int          N_BYTES  = 4,
   parameter logic [7:0]  CMD_BYTE = 8'h52,
   parameter logic [7:0]  HEADER   = 8'hA5,
   parameter int          TIMEOUT  = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_data,
   output logic                   calc_start,
   input  logic                   calc_done,
   input  logic [8*N_BYTES-1:0]   res_data,
   output logic                   tx_start,
   output logic [7:0]             tx_data,
   input  logic                   tx_busy,
   output logic                   busy,
   output logic                   err_overrun,
   output logic                   err_timeout
);

   localparam int RW = 8 * N_BYTES;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int IW = $clog2(N_BYTES + 2);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT);
   localparam logic [IW-1:0] IDX_LAST_RES = IW'(N_BYTES);
   localparam logic [IW-1:0] IDX_CSUM     = IW'(N_BYTES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_SEND,
      S_ACK,
      S_DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic            calc_start_q, calc_start_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [RW-1:0]   shift_q, shift_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [7:0]      csum_q, csum_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovr_q, ovr_d;
   logic            tmo_q, tmo_d;

   logic            cmd_hit;
   logic            tmo_hit;
   logic [7:0]      top_byte;

   assign cmd_hit  = rx_valid && (rx_data == CMD_BYTE);
   assign tmo_hit  = (cnt_q >= TMO_LAST);
   assign top_byte = shift_q[RW-1 -: 8];

   always_comb begin
      state_d      = state_q;
      calc_start_d = 1'b0;
      tx_data_d    = tx_data_q;
      shift_d      = shift_q;
      idx_d        = idx_q;
      csum_d       = csum_q;
      cnt_d        = cnt_q;
      ovr_d        = ovr_q;
      tmo_d        = tmo_q;

      // Any command seen outside IDLE, including the cycle that returns to IDLE, is dropped.
      if (cmd_hit && (state_q != S_IDLE)) begin
         ovr_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_hit) begin
               state_d      = S_CALC;
               calc_start_d = 1'b1;
               ovr_d        = 1'b0;
               tmo_d        = 1'b0;
               cnt_d        = '0;
            end
         end
         S_CALC: begin
            if (calc_done) begin
               state_d   = S_SEND;
               tx_data_d = HEADER;
               shift_d   = res_data;
               idx_d     = '0;
               csum_d    = 8'h00;
            end else if (tmo_hit) begin
               state_d = S_IDLE;
               tmo_d   = 1'b1;
            end else if (cnt_q != TMO_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_SEND: begin
            state_d = S_ACK;
            cnt_d   = '0;
         end
         S_ACK: begin
            if (tx_busy) begin
               state_d = S_DRAIN;
            end else if (tmo_hit) begin
               state_d = S_IDLE;
               tmo_d   = 1'b1;
            end else if (cnt_q != TMO_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            if (!tx_busy) begin
               if (idx_q == IDX_CSUM) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_SEND;
                  idx_d   = idx_q + IW'(1);
                  // Checksum already holds every result byte once the last one has gone out.
                  if (idx_q == IDX_LAST_RES) begin
                     tx_data_d = csum_q;
                  end else begin
                     tx_data_d = top_byte;
                     shift_d   = shift_q << 8;
                     csum_d    = csum_q + top_byte;
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         calc_start_q <= 1'b0;
         tx_data_q    <= 8'h00;
         shift_q      <= '0;
         idx_q        <= '0;
         csum_q       <= 8'h00;
         cnt_q        <= '0;
         ovr_q        <= 1'b0;
         tmo_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         calc_start_q <= calc_start_d;
         tx_data_q    <= tx_data_d;
         shift_q      <= shift_d;
         idx_q        <= idx_d;
         csum_q       <= csum_d;
         cnt_q        <= cnt_d;
         ovr_q        <= ovr_d;
         tmo_q        <= tmo_d;
      end
   end

   assign calc_start  = calc_start_q;
   assign tx_start    = (state_q == S_SEND);
   assign tx_data     = tx_data_q;
   assign busy        = (state_q != S_IDLE);
   assign err_overrun = ovr_q;
   assign err_timeout = tmo_q;

endmodule

// File: tb/tb_uart_result_sequencer.sv
// tb/tb_uart_result_sequencer.sv - self-checking bench for uart_result_sequencer
// Compute block and UART are behavioural responders; frames are checked against a byte-list model.
module tb_uart_result_sequencer;

   localparam int         NB        = 4;
   localparam int         TMO       = 16;
   localparam logic [7:0] HDR       = 8'hA5;
   localparam logic [7:0] CMD       = 8'h52;
   localparam int         UART_BUSY = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        calc_done = 1'b0;
   logic [31:0] res_data = 32'h0;
   logic        tx_busy = 1'b0;
   logic        calc_start, tx_start, busy, err_overrun, err_timeout;
   logic [7:0]  tx_data;

   int n_asrt = 0;
   int n_fail = 0;
   int cyc = 0;

   logic        uart_en = 1'b1;
   logic        calc_en = 1'b1;
   logic        stray_en = 1'b0;
   logic [31:0] next_res = 32'h0;
   int          idle_req = 0;
   int          idle_seen = 0;
   int          pend = -1;
   int          stray_cnt = -1;
   int          calc_starts = 0;
   int          done_cyc = 0;
   int          busy_cnt = 0;
   int          viol_busy = 0;
   int          viol_stable = 0;
   logic [7:0]  cur_byte = 8'h00;
   logic [7:0]  tx_q[$];
   int          tx_cyc_q[$];
   int          last_rx_cyc = 0;

   uart_result_sequencer #(
      .N_BYTES (NB),
      .CMD_BYTE(CMD),
      .HEADER  (HDR),
      .TIMEOUT (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .calc_start (calc_start),
      .calc_done  (calc_done),
      .res_data   (res_data),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_busy    (tx_busy),
      .busy       (busy),
      .err_overrun(err_overrun),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Compute block: one-cycle done pulse 1..4 cycles after calc_start, optional stray pulses.
   always @(negedge clk) begin
      if (calc_done) begin
         calc_done = 1'b0;
         res_data  = $urandom;
      end
      if (!rst) begin
         pend      = -1;
         stray_cnt = -1;
      end else begin
         if (calc_start) begin
            calc_starts++;
            if (calc_en) pend = $urandom_range(1, 4);
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               calc_done = 1'b1;
               res_data  = next_res;
               done_cyc  = cyc;
               pend      = -1;
               if (stray_en) stray_cnt = 3;
            end
         end else if (stray_cnt > 0) begin
            stray_cnt--;
            if (stray_cnt == 0) begin
               calc_done = 1'b1;
               res_data  = $urandom;
               stray_cnt = -1;
            end
         end
         if (idle_req != idle_seen) begin
            idle_seen = idle_req;
            calc_done = 1'b1;
            res_data  = $urandom;
         end
      end
   end

   // UART: busy for UART_BUSY cycles starting in the tx_start cycle.
   always @(negedge clk) begin
      if (busy_cnt > 0) busy_cnt--;
      if (tx_start === 1'b1) begin
         if (tx_busy) viol_busy++;
         tx_q.push_back(tx_data);
         tx_cyc_q.push_back(cyc);
         cur_byte = tx_data;
         if (uart_en) busy_cnt = UART_BUSY;
      end else if (tx_busy && (busy === 1'b1) && (tx_data !== cur_byte)) begin
         viol_stable++;
      end
      tx_busy = (busy_cnt > 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500000");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic int cyc_at(input int i);
      if (i < tx_cyc_q.size()) return tx_cyc_q[i];
      return -1;
   endfunction

   function automatic logic [7:0] tx_at(input int i);
      if (i < tx_q.size()) return tx_q[i];
      return 8'hxx;
   endfunction

   task automatic send_rx(input logic [7:0] b);
      @(negedge clk);
      rx_valid    = 1'b1;
      rx_data     = b;
      last_rx_cyc = cyc;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_idle(input string tag, output int fall_cyc);
      int n = 0;
      while (busy !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      fall_cyc = cyc;
      chk1(tag, n < 2000, 1'b1);
   endtask

   task automatic wait_tx(input string tag, input int target);
      int n = 0;
      while (tx_q.size() < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk1(tag, n < 2000, 1'b1);
   endtask

   // Expected frame: header, bytes of r from the most significant down, then their sum mod 256.
   task automatic check_frame(input string tag, input int base, input logic [31:0] r);
      int         sum = 0;
      logic [7:0] exp_b;
      chk($sformatf("%s length", tag), tx_q.size(), base + NB + 2);
      for (int i = 0; i < NB + 2; i++) begin
         if (i == 0) begin
            exp_b = HDR;
         end else if (i <= NB) begin
            exp_b = 8'((r >> (8 * (NB - i))) & 32'hFF);
            sum  += int'(exp_b);
         end else begin
            exp_b = 8'(sum % 256);
         end
         chk($sformatf("%s byte%0d", tag, i), 32'(tx_at(base + i)), 32'(exp_b));
      end
      for (int i = 0; i < NB + 1; i++) begin
         chk($sformatf("%s gap%0d", tag, i), cyc_at(base + i + 1) - cyc_at(base + i), UART_BUSY + 1);
      end
   endtask

   task automatic run_frame(input string tag, input logic [31:0] r, output int base, output int fall);
      int sc;
      base     = tx_q.size();
      sc       = calc_starts;
      next_res = r;
      send_rx(CMD);
      wait_idle($sformatf("%s done", tag), fall);
      check_frame(tag, base, r);
      chk($sformatf("%s calc_start pulses", tag), calc_starts - sc, 1);
      chk1($sformatf("%s err_overrun", tag), err_overrun, 1'b0);
      chk1($sformatf("%s err_timeout", tag), err_timeout, 1'b0);
   endtask

   initial begin
      int          base, fall, t0, sc, s_last;
      logic [31:0] r;

      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk1("rst calc_start", calc_start, 1'b0);
      chk1("rst tx_start", tx_start, 1'b0);
      chk("rst tx_data", 32'(tx_data), 32'h0);
      chk1("rst busy", busy, 1'b0);
      chk1("rst err_overrun", err_overrun, 1'b0);
      chk1("rst err_timeout", err_timeout, 1'b0);
      rst = 1'b1;

      send_rx(8'h41);
      chk1("idle 41 busy", busy, 1'b0);
      send_rx(8'h00);
      idle_req++;
      repeat (6) @(negedge clk);
      chk("idle calc_starts", calc_starts, 0);
      chk1("idle busy", busy, 1'b0);
      chk1("idle err_overrun", err_overrun, 1'b0);
      chk1("idle err_timeout", err_timeout, 1'b0);
      chk("idle tx count", tx_q.size(), 0);

      run_frame("f01020304", 32'h01020304, base, fall);
      chk("first tx latency", cyc_at(base), done_cyc + 1);
      chk("busy fall", fall, cyc_at(base + NB + 1) + UART_BUSY + 1);

      stray_en = 1'b1;
      run_frame("fFFFFFFFF", 32'hFFFFFFFF, base, fall);
      for (int k = 0; k < 3; k++) begin
         r = $urandom;
         run_frame($sformatf("rand%0d", k), r, base, fall);
      end

      r        = $urandom;
      next_res = r;
      base     = tx_q.size();
      sc       = calc_starts;
      send_rx(CMD);
      wait_tx("ovr reach byte2", base + 3);
      send_rx(CMD);
      wait_idle("ovr done", fall);
      check_frame("ovr frame", base, r);
      chk1("ovr err_overrun", err_overrun, 1'b1);
      chk("ovr calc_start pulses", calc_starts - sc, 1);

      r        = $urandom;
      next_res = r;
      base     = tx_q.size();
      sc       = calc_starts;
      send_rx(CMD);
      chk1("ovr cleared by accept", err_overrun, 1'b0);
      wait_tx("edge reach last", base + NB + 2);
      s_last = cyc_at(base + NB + 1);
      wait_cyc(s_last + UART_BUSY);
      rx_valid = 1'b1;
      rx_data  = CMD;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      wait_idle("edge done", fall);
      check_frame("edge frame", base, r);
      repeat (5) @(negedge clk);
      chk1("edge busy stays 0", busy, 1'b0);
      chk1("edge err_overrun", err_overrun, 1'b1);
      chk("edge calc_start pulses", calc_starts - sc, 1);

      stray_en = 1'b0;
      uart_en  = 1'b0;
      base     = tx_q.size();
      next_res = $urandom;
      send_rx(CMD);
      wait_tx("ack to tx", base + 1);
      t0 = cyc_at(base);
      wait_cyc(t0 + TMO);
      chk1("ack to busy before", busy, 1'b1);
      chk1("ack to err before", err_timeout, 1'b0);
      @(negedge clk);
      chk1("ack to busy after", busy, 1'b0);
      chk1("ack to err after", err_timeout, 1'b1);
      repeat (20) @(negedge clk);
      chk("ack to tx count", tx_q.size(), base + 1);
      chk("ack to header", 32'(tx_at(base)), 32'(HDR));
      uart_en = 1'b1;

      calc_en = 1'b0;
      sc      = calc_starts;
      base    = tx_q.size();
      send_rx(CMD);
      t0 = last_rx_cyc + 1;
      chk1("calc to err cleared", err_timeout, 1'b0);
      wait_cyc(t0 + TMO - 1);
      chk1("calc to busy before", busy, 1'b1);
      chk1("calc to err before", err_timeout, 1'b0);
      @(negedge clk);
      chk1("calc to busy after", busy, 1'b0);
      chk1("calc to err after", err_timeout, 1'b1);
      repeat (5) @(negedge clk);
      chk("calc to tx count", tx_q.size(), base);
      chk("calc to calc_start pulses", calc_starts - sc, 1);
      calc_en = 1'b1;

      next_res = $urandom;
      base     = tx_q.size();
      sc       = calc_starts;
      send_rx(CMD);
      wait_tx("rst reach byte1", base + 2);
      send_rx(CMD);
      wait_tx("rst reach byte2", base + 3);
      chk1("rst mid err_overrun set", err_overrun, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk1("arst calc_start", calc_start, 1'b0);
      chk1("arst tx_start", tx_start, 1'b0);
      chk("arst tx_data", 32'(tx_data), 32'h0);
      chk1("arst busy", busy, 1'b0);
      chk1("arst err_overrun", err_overrun, 1'b0);
      chk1("arst err_timeout", err_timeout, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      chk("post rst tx count", tx_q.size(), base + 3);
      chk1("post rst busy", busy, 1'b0);
      chk("post rst calc_start pulses", calc_starts - sc, 1);

      r = $urandom;
      run_frame("recover", r, base, fall);

      chk("tx_start while tx_busy", viol_busy, 0);
      chk("tx_data unstable", viol_stable, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_result_sequencer.md
UART_RESULT_SEQUENCER -- requirements
Module: uart_result_sequencer

Interface
REQ-001 SHALL have parameter N_BYTES, default 4, number of result bytes per frame (1..16).
REQ-002 SHALL have parameter CMD_BYTE, default 8'h52, received byte that requests a result.
REQ-003 SHALL have parameter HEADER, default 8'hA5, first byte of every frame.
REQ-004 SHALL have parameter TIMEOUT, default 1024, maximum wait in cycles for calc_done or for tx_busy to rise.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port rx_valid  input  1  one-cycle pulse from the UART receiver.
REQ-008 SHALL have port rx_data  input  8  received byte, valid while rx_valid=1.
REQ-009 SHALL have port calc_start  output  1  one-cycle pulse that starts the compute block.
REQ-010 SHALL have port calc_done  input  1  compute block result ready, level or pulse.
REQ-011 SHALL have port res_data  input  8*N_BYTES  compute result, valid while calc_done=1.
REQ-012 SHALL have port tx_start  output  1  one-cycle transmit pulse to the UART.
REQ-013 SHALL have port tx_data  output  8  byte to transmit, held stable from tx_start until the byte completes.
REQ-014 SHALL have port tx_busy  input  1  UART is_transmitting.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port err_overrun  output  1  sticky: a command was dropped.
REQ-017 SHALL have port err_timeout  output  1  sticky: a frame was aborted on timeout.

Function
REQ-018 SHALL implement the FSM states IDLE, CALC, SEND, ACK, DRAIN.
REQ-019 In IDLE, rx_valid=1 with rx_data==CMD_BYTE SHALL:
- pulse calc_start in the next cycle;
- clear err_overrun and err_timeout;
- enter CALC.
REQ-020 In IDLE, bytes other than CMD_BYTE SHALL be ignored with no output change.
REQ-021 In CALC, calc_done=1 SHALL:
- latch res_data into an internal shift register;
- set the byte index to 0 and the checksum to 0;
- enter SEND.
REQ-022 Frame order SHALL be: HEADER, then result bytes MSB first (res_data[8*N_BYTES-1 -: 8] first), then the checksum byte; N_BYTES+2 bytes in total.
REQ-023 The checksum SHALL be the modulo-256 sum of the N_BYTES result bytes only, excluding HEADER, with carries discarded.
REQ-024 SEND SHALL drive tx_data with the current byte, pulse tx_start for exactly one cycle, and enter ACK.
REQ-025 The first tx_start SHALL occur 1 cycle after the cycle in which calc_done is sampled high.
REQ-026 ACK SHALL wait for tx_busy=1, then enter DRAIN; the ACK wait counter SHALL be reset on entering ACK.
REQ-027 DRAIN SHALL wait for tx_busy=0, then either:
- advance the byte index and return to SEND; or
- if the last byte (the checksum) has completed, go to IDLE.
REQ-028 tx_start SHALL never be asserted while tx_busy=1.
REQ-029 The minimum gap from tx_busy falling to the next tx_start SHALL be 1 cycle.
REQ-030 If TIMEOUT cycles elapse in CALC without calc_done, or in ACK without tx_busy=1, the block SHALL:
- set err_timeout;
- drop the frame;
- return to IDLE with no further tx_start.
REQ-031 A CMD_BYTE received while busy=1 SHALL be discarded and SHALL set err_overrun; the frame in progress SHALL continue unaffected.
REQ-032 calc_done outside CALC SHALL be ignored; res_data SHALL be sampled only at the CALC exit edge.
REQ-033 If rx_valid=1 with CMD_BYTE arrives in the same cycle the FSM returns to IDLE, it SHALL be treated as overrun (dropped).
REQ-034 The timeout counter SHALL saturate and not wrap; its width SHALL be clog2(TIMEOUT+1).

Reset
REQ-035 rst=0 SHALL immediately force, with no clock required:
- IDLE;
- calc_start=0, tx_start=0, tx_data=8'h00, busy=0;
- err_overrun=0, err_timeout=0;
- counters, index and checksum cleared.
REQ-036 Reset asserted mid-frame SHALL abort the frame; no residual tx_start SHALL follow deassertion.
REQ-037 Deassertion SHALL take effect on the first rising clk edge after rst returns to 1.

Verification
REQ-038 N_BYTES=4, res_data=32'h01020304, UART model busy 10 cycles per byte, send 8'h52 -> calc_start one pulse, tx bytes A5 01 02 03 04 0A, busy falls after the last drain.
REQ-039 res_data=32'hFFFFFFFF -> frame A5 FF FF FF FF FC (checksum wraps mod 256).
REQ-040 Second 8'h52 during byte 2 of a frame -> frame completes unchanged, err_overrun=1, only one calc_start; next accepted command clears err_overrun.
REQ-041 tx_busy tied 0, TIMEOUT=16 -> exactly one tx_start (A5), err_timeout=1 after 16 cycles in ACK, busy=0; the same applies with calc_done tied 0 and no tx_start at all.
REQ-042 rst=0 pulse during byte 3 -> all outputs 0 asynchronously; after release, no tx_start until a new 8'h52 is received.
REQ-043 rx bytes 8'h41 and 8'h00 in IDLE -> no calc_start, busy stays 0, error flags unchanged.
